// File: rtl/rsa_modexp_decrypt_if.sv
// Request/result bundle between the ciphertext/key source and the RSA decryption engine.
interface rsa_modexp_decrypt_if #(
  parameter int W = 24
);
  logic         start;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W-1:0] n;
  logic [W-1:0] m;
  logic         busy;
  logic         done;
  logic         err;

  modport master (output start, c, d, n, input  m, busy, done, err);
  modport slave  (input  start, c, d, n, output m, busy, done, err);
endinterface

// File: rtl/rsa_modexp_decrypt.sv
// RSA decryption engine: m = c^d mod n by left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier, one multiplier step per clock.
module rsa_modexp_decrypt #(
  parameter int W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  rsa_modexp_decrypt_if.slave  bus
);
  localparam int IW = $clog2(W);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_SQR, S_MUL, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_c, r_d, r_n, r_acc, r_m;
  logic [W+1:0]  r_r;
  logic [IW-1:0] r_i, r_k;
  logic          r_busy, r_done, r_err;

  logic          w_op_err, w_last, w_finish, w_k_dec, w_bit;
  logic [W-1:0]  w_b;
  logic [W+1:0]  w_n_ext, w_sum, w_sub1, w_sub2;

  assign w_op_err = (bus.n < W'(2)) || (bus.c >= bus.n);
  assign w_last   = (r_i == '0);

  // One interleaved step: R = 2R + b[i]*a, then up to two conditional
  // subtractions; 2R + a < 3n, so the result is back below n.
  assign w_b     = (r_state == S_MUL) ? r_c : r_acc;
  assign w_bit   = w_b[r_i];
  assign w_n_ext = {2'b00, r_n};
  assign w_sum   = (r_r << 1) + (w_bit ? {2'b00, r_acc} : '0);
  assign w_sub1  = (w_sum  >= w_n_ext) ? (w_sum  - w_n_ext) : w_sum;
  assign w_sub2  = (w_sub1 >= w_n_ext) ? (w_sub1 - w_n_ext) : w_sub1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_next   = r_state;
    w_finish = 1'b0;
    w_k_dec  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = w_op_err ? S_ERR : S_SQR;
      S_ERR:  w_next = S_DONE;
      S_SQR: begin
        if (w_last) begin
          if (r_d[r_k]) begin
            w_next = S_MUL;
          end else if (r_k == '0) begin
            w_next   = S_DONE;
            w_finish = 1'b1;
          end else begin
            w_k_dec = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (w_last) begin
          if (r_k == '0) begin
            w_next   = S_DONE;
            w_finish = 1'b1;
          end else begin
            w_next  = S_SQR;
            w_k_dec = 1'b1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c    <= '0;
      r_d    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_m    <= '0;
      r_r    <= '0;
      r_i    <= '0;
      r_k    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_c    <= bus.c;
            r_d    <= bus.d;
            r_n    <= bus.n;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            r_acc  <= W'(1);
            r_r    <= '0;
            r_i    <= IW'(W - 1);
            r_k    <= IW'(W - 1);
          end
        end
        S_ERR: begin
          r_err  <= 1'b1;
          r_m    <= '0;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        S_SQR, S_MUL: begin
          if (w_last) begin
            r_acc <= w_sub2[W-1:0];
            r_r   <= '0;
            r_i   <= IW'(W - 1);
            if (w_k_dec) r_k <= r_k - 1'b1;
            if (w_finish) begin
              r_m    <= w_sub2[W-1:0];
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
          end else begin
            r_r <= w_sub2;
            r_i <= r_i - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m    = r_m;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Bench for rsa_modexp_decrypt: directed operations checked each cycle against
// a plain-arithmetic model of result, latency, busy/done/err and result hold.
module tb_rsa_modexp_decrypt;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rsa_modexp_decrypt_if #(.W(W)) bus ();
  rsa_modexp_decrypt #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: the accepted operation and the values the outputs must hold.
  bit     active   = 1'b0;
  longint t0       = 0;
  longint done_at  = -10;
  longint exp_m    = 0;
  bit     exp_err  = 1'b0;
  longint held_m   = 0;
  bit     held_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Power by repeated modular multiplication; independent of any bit-serial scheme.
  function automatic longint modexp(input longint c_i, input longint d_i, input longint n_i);
    longint r = 1 % n_i;
    for (longint k = 0; k < d_i; k++) r = (r * c_i) % n_i;
    return r;
  endfunction

  always @(negedge clk) begin
    bit exp_busy, exp_done;
    if (active && cyc == t0)      held_err = 1'b0;
    if (active && cyc == done_at) begin
      held_m   = exp_m;
      held_err = exp_err;
    end
    exp_busy = active && (cyc >= t0) && (cyc < done_at);
    exp_done = active && (cyc == done_at);
    check("busy", bus.busy, exp_busy);
    check("done", bus.done, exp_done);
    check("m",    bus.m,    held_m);
    check("err",  bus.err,  held_err);
    if (exp_done) active = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input longint target);
    while (cyc < target) step();
  endtask

  // Present start for one edge; the model decides whether the engine takes it.
  task automatic launch(input longint c_i, input longint d_i, input longint n_i);
    longint e;
    bus.start = 1'b1;
    bus.c     = W'(c_i);
    bus.d     = W'(d_i);
    bus.n     = W'(n_i);
    e = cyc + 1;
    if (e > done_at + 1) begin
      active  = 1'b1;
      t0      = e;
      exp_err = (n_i < 2) || (c_i >= n_i);
      done_at = exp_err ? e + 1 : e + W * (W + $countones(d_i));
      exp_m   = exp_err ? 0 : modexp(c_i, d_i, n_i);
    end
    step();
    bus.start = 1'b0;
    bus.c     = W'($urandom);
    bus.d     = W'($urandom);
    bus.n     = W'($urandom);
  endtask

  task automatic do_op(input longint c_i, input longint d_i, input longint n_i,
                       input longint lit_m, input bit lit_err);
    step();
    launch(c_i, d_i, n_i);
    check("busy_at_start", bus.busy, 1);
    check("err_at_start",  bus.err,  0);
    wait_until(done_at);
    check("lit_done", bus.done, 1);
    check("lit_m",    bus.m,    lit_m);
    check("lit_err",  bus.err,  lit_err);
  endtask

  initial begin
    longint first_t0;
    bus.start = 1'b0;
    bus.c     = '0;
    bus.d     = '0;
    bus.n     = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_m",    bus.m,    0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err",  bus.err,  0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Starts during busy carry other operands and must be ignored.
    step();
    launch(2790, 2753, 3233);
    first_t0 = t0;
    wait_until(first_t0 + 9);
    launch(5, 1, 7);
    wait_until(first_t0 + 299);
    launch(1, 0, 3233);
    wait_until(first_t0 + 695);
    check("done_before_696", bus.done, 0);
    check("busy_at_695",     bus.busy, 1);
    step();
    check("done_at_696", bus.done, 1);
    check("m_3233",      bus.m,    65);
    check("err_3233",    bus.err,  0);

    // Start on the done cycle is dropped; the following one is taken.
    launch(1, 0, 3233);
    check("busy_after_done_start", bus.busy, 0);
    launch(5, 1, 7);
    wait_until(done_at);
    check("lat_600", done_at - t0, 600);
    check("m_5_1_7", bus.m, 5);

    do_op(1234, 0, 3233, 1, 1'b0);
    do_op(16777212, 2, 16777213, 1, 1'b0);
    do_op(2, 23, 16777213, 8388608, 1'b0);

    // Asynchronous reset in the middle of an operation.
    step();
    launch(2790, 2753, 3233);
    wait_until(t0 + 349);
    #2 rst = 1'b1;
    active   = 1'b0;
    done_at  = -10;
    held_m   = 0;
    held_err = 1'b0;
    #1;
    check("mid_rst_m",    bus.m,    0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_err",  bus.err,  0);
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    do_op(2790, 2753, 3233, 65, 1'b0);

    do_op(0, 5, 1, 0, 1'b1);
    check("err_lat", done_at - t0, 1);
    do_op(3233, 5, 3233, 0, 1'b1);
    do_op(0, 5, 3233, 0, 1'b0);

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
